// File: rtl/strassen_pkg.sv
// ---------------------------------------------------------------------------
// strassen_pkg
// Shared definitions for the sequential 2x2 Strassen multiplier:
//   - state_t        : controller states (IDLE, MUL, COMB, DONE)
//   - M1_IDX..M7_IDX : step index of each Strassen product on the multiplier
//   - STEP_LAST      : final multiply step, after which the combine runs
//   - op_width()     : width of one extended multiplier operand
//   - int_width()    : width of products and of the combine adder
// ---------------------------------------------------------------------------
package strassen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        COMB = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int STEP_W = 3;

    localparam logic [STEP_W-1:0] M1_IDX    = 3'd0;
    localparam logic [STEP_W-1:0] M2_IDX    = 3'd1;
    localparam logic [STEP_W-1:0] M3_IDX    = 3'd2;
    localparam logic [STEP_W-1:0] M4_IDX    = 3'd3;
    localparam logic [STEP_W-1:0] M5_IDX    = 3'd4;
    localparam logic [STEP_W-1:0] M6_IDX    = 3'd5;
    localparam logic [STEP_W-1:0] M7_IDX    = 3'd6;
    localparam logic [STEP_W-1:0] STEP_LAST = 3'd6;

    // Operand sums/differences carry one growth bit plus one sign bit, so an
    // unsigned difference such as B12-B22 is still held exactly.
    function automatic int op_width(input int data_w);
        return data_w + 2;
    endfunction

    // Internal precision for products and the combine adder.
    function automatic int int_width(input int data_w);
        return 2 * data_w + 4;
    endfunction

endpackage

// File: rtl/strassen_operand_sel.sv
// ---------------------------------------------------------------------------
// strassen_operand_sel
// Combinational operand mux for the shared multiplier. For the current step
// it forms the two Strassen factors from the latched A/B elements, extended
// (sign or zero per SIGNED) to op_width(DATA_W) bits and returned as
// two's-complement values.
// Ports:
//   step                 in   current multiply step (M1_IDX..M7_IDX)
//   a11,a12,a21,a22      in   latched matrix A, DATA_W each
//   b11,b12,b21,b22      in   latched matrix B, DATA_W each
//   op_x, op_y           out  left/right multiplier factor, op_width bits
// ---------------------------------------------------------------------------
module strassen_operand_sel
    import strassen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int SIGNED = 1
) (
    input  logic [STEP_W-1:0]            step,
    input  logic [DATA_W-1:0]            a11,
    input  logic [DATA_W-1:0]            a12,
    input  logic [DATA_W-1:0]            a21,
    input  logic [DATA_W-1:0]            a22,
    input  logic [DATA_W-1:0]            b11,
    input  logic [DATA_W-1:0]            b12,
    input  logic [DATA_W-1:0]            b21,
    input  logic [DATA_W-1:0]            b22,
    output logic [op_width(DATA_W)-1:0]  op_x,
    output logic [op_width(DATA_W)-1:0]  op_y
);

    localparam int OP_W = op_width(DATA_W);

    function automatic logic [OP_W-1:0] ext(input logic [DATA_W-1:0] v);
        if (SIGNED != 0) begin
            return {{2{v[DATA_W-1]}}, v};
        end
        return {2'b00, v};
    endfunction

    always_comb begin
        op_x = '0;
        op_y = '0;
        case (step)
            M1_IDX: begin
                op_x = ext(a11) + ext(a22);
                op_y = ext(b11) + ext(b22);
            end
            M2_IDX: begin
                op_x = ext(a21) + ext(a22);
                op_y = ext(b11);
            end
            M3_IDX: begin
                op_x = ext(a11);
                op_y = ext(b12) - ext(b22);
            end
            M4_IDX: begin
                op_x = ext(a22);
                op_y = ext(b21) - ext(b11);
            end
            M5_IDX: begin
                op_x = ext(a11) + ext(a12);
                op_y = ext(b22);
            end
            M6_IDX: begin
                op_x = ext(a21) - ext(a11);
                op_y = ext(b11) + ext(b12);
            end
            M7_IDX: begin
                op_x = ext(a12) - ext(a22);
                op_y = ext(b21) + ext(b22);
            end
            default: begin
                op_x = '0;
                op_y = '0;
            end
        endcase
    end

endmodule

// File: rtl/strassen_2x2_seq.sv
// ---------------------------------------------------------------------------
// strassen_2x2_seq
// Sequential 2x2 Strassen matrix multiplier. One multiplier is reused for
// the seven products M1..M7 (one per cycle), then C11..C22 are formed and
// registered in a single combine cycle. Latency from accept edge to
// out_valid is 8 cycles; minimum initiation interval is 10 cycles.
// Internal arithmetic is exact; reduction to OUT_W happens only when the
// C registers are loaded.
//
// Build option:
//   STRASSEN_SAT_EN  defined   : each C clamps to the OUT_W range
//                    undefined : low OUT_W bits are kept (wrap)
//
// Ports:
//   clk                  in   clock, rising edge
//   rst_n                in   synchronous active-low reset
//   in_valid / in_ready  in/out  operand handshake (ready only in IDLE)
//   a11..a22, b11..b22   in   matrices A and B, DATA_W each
//   out_valid/out_ready  out/in  result handshake
//   c11..c22             out  C = A*B, OUT_W each
//   busy                 out  high in any state other than IDLE
// ---------------------------------------------------------------------------
module strassen_2x2_seq
    import strassen_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OUT_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] a12,
    input  logic [DATA_W-1:0] a21,
    input  logic [DATA_W-1:0] a22,
    input  logic [DATA_W-1:0] b11,
    input  logic [DATA_W-1:0] b12,
    input  logic [DATA_W-1:0] b21,
    input  logic [DATA_W-1:0] b22,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  c11,
    output logic [OUT_W-1:0]  c12,
    output logic [OUT_W-1:0]  c21,
    output logic [OUT_W-1:0]  c22,
    output logic              busy
);

    localparam int OP_W  = op_width(DATA_W);
    localparam int INT_W = int_width(DATA_W);

`ifdef STRASSEN_SAT_EN
    // One bit wider than both the exact value and the output, so every
    // clamp bound is representable as a positive/negative signed constant.
    localparam int WIDE = ((INT_W > OUT_W) ? INT_W : OUT_W) + 1;
    localparam logic signed [WIDE-1:0] SMAX = {{(WIDE-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [WIDE-1:0] SMIN = {{(WIDE-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
    localparam logic signed [WIDE-1:0] UMAX = {{(WIDE-OUT_W){1'b0}}, {OUT_W{1'b1}}};
`endif

    state_t                   state;
    state_t                   next_state;
    logic [STEP_W-1:0]        step;

    logic [DATA_W-1:0]        a11_r, a12_r, a21_r, a22_r;
    logic [DATA_W-1:0]        b11_r, b12_r, b21_r, b22_r;

    logic signed [INT_W-1:0]  m_r [0:6];

    logic [OP_W-1:0]          op_x;
    logic [OP_W-1:0]          op_y;
    logic signed [INT_W-1:0]  product;

    logic signed [INT_W-1:0]  c11_full, c12_full, c21_full, c22_full;

    strassen_operand_sel #(
        .DATA_W (DATA_W),
        .SIGNED (SIGNED)
    ) u_operand_sel (
        .step (step),
        .a11  (a11_r),
        .a12  (a12_r),
        .a21  (a21_r),
        .a22  (a22_r),
        .b11  (b11_r),
        .b12  (b12_r),
        .b21  (b21_r),
        .b22  (b22_r),
        .op_x (op_x),
        .op_y (op_y)
    );

    // Both factors are two's-complement regardless of SIGNED; widening them
    // to INT_W first keeps the product exact.
    assign product = INT_W'($signed(op_x)) * INT_W'($signed(op_y));

    // Intermediate sums may wrap in INT_W, but each final C fits, so the
    // modular result equals the exact one.
    assign c11_full = m_r[0] + m_r[3] - m_r[4] + m_r[6];
    assign c12_full = m_r[2] + m_r[4];
    assign c21_full = m_r[1] + m_r[3];
    assign c22_full = m_r[0] - m_r[1] + m_r[2] + m_r[5];

    function automatic logic [OUT_W-1:0] reduce_out(input logic signed [INT_W-1:0] v);
`ifdef STRASSEN_SAT_EN
        logic signed [WIDE-1:0] w;
        w = WIDE'(v);
        if (SIGNED != 0) begin
            if (w > SMAX) return OUT_W'(SMAX);
            if (w < SMIN) return OUT_W'(SMIN);
        end else begin
            if (w[WIDE-1]) return '0;
            if (w > UMAX) return OUT_W'(UMAX);
        end
`endif
        return OUT_W'(v);
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)           next_state = MUL;
            MUL:     if (step == STEP_LAST)  next_state = COMB;
            COMB:                            next_state = DONE;
            DONE:    if (out_ready)          next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Datapath: operand latch, product registers, result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step      <= '0;
            out_valid <= 1'b0;
            c11       <= '0;
            c12       <= '0;
            c21       <= '0;
            c22       <= '0;
            a11_r     <= '0;
            a12_r     <= '0;
            a21_r     <= '0;
            a22_r     <= '0;
            b11_r     <= '0;
            b12_r     <= '0;
            b21_r     <= '0;
            b22_r     <= '0;
            for (int i = 0; i < 7; i++) begin
                m_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a11_r <= a11;
                        a12_r <= a12;
                        a21_r <= a21;
                        a22_r <= a22;
                        b11_r <= b11;
                        b12_r <= b12;
                        b21_r <= b21;
                        b22_r <= b22;
                        step  <= '0;
                    end
                end
                MUL: begin
                    for (int i = 0; i < 7; i++) begin
                        if (step == STEP_W'(i)) begin
                            m_r[i] <= product;
                        end
                    end
                    if (step != STEP_LAST) begin
                        step <= step + 3'd1;
                    end
                end
                COMB: begin
                    c11       <= reduce_out(c11_full);
                    c12       <= reduce_out(c12_full);
                    c21       <= reduce_out(c21_full);
                    c22       <= reduce_out(c22_full);
                    out_valid <= 1'b1;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_strassen_2x2_seq.sv
// ---------------------------------------------------------------------------
// tb_strassen_2x2_seq
// Drives three instances in lock-step with the same operand bit patterns:
//   d=0 : DATA_W=OUT_W=32, signed
//   d=1 : DATA_W=OUT_W=8,  signed   (low bytes of the operands)
//   d=2 : DATA_W=OUT_W=8,  unsigned (low bytes of the operands)
// Expected results come from a plain row-by-column matrix product on wide
// integers, then wrapped or clamped to the output width.
// Build option STRASSEN_SAT_EN selects the clamping expectation.
// ---------------------------------------------------------------------------
module tb_strassen_2x2_seq;

    typedef logic [31:0] mat_t [4];

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a [4];
    logic [31:0] b [4];

    logic [31:0] c32 [4];
    logic [7:0]  c8s [4];
    logic [7:0]  c8u [4];
    logic        ov   [3];
    logic        irdy [3];
    logic        bsy  [3];
    logic [31:0] got   [3][4];
    logic [31:0] exp_c [3][4];

    int asserts;
    int fails;

    strassen_2x2_seq #(.DATA_W(32), .OUT_W(32), .SIGNED(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[0]),
        .a11(a[0]), .a12(a[1]), .a21(a[2]), .a22(a[3]),
        .b11(b[0]), .b12(b[1]), .b21(b[2]), .b22(b[3]),
        .out_valid(ov[0]), .out_ready(out_ready),
        .c11(c32[0]), .c12(c32[1]), .c21(c32[2]), .c22(c32[3]),
        .busy(bsy[0])
    );

    strassen_2x2_seq #(.DATA_W(8), .OUT_W(8), .SIGNED(1)) dut8s (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[1]),
        .a11(a[0][7:0]), .a12(a[1][7:0]), .a21(a[2][7:0]), .a22(a[3][7:0]),
        .b11(b[0][7:0]), .b12(b[1][7:0]), .b21(b[2][7:0]), .b22(b[3][7:0]),
        .out_valid(ov[1]), .out_ready(out_ready),
        .c11(c8s[0]), .c12(c8s[1]), .c21(c8s[2]), .c22(c8s[3]),
        .busy(bsy[1])
    );

    strassen_2x2_seq #(.DATA_W(8), .OUT_W(8), .SIGNED(0)) dut8u (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(irdy[2]),
        .a11(a[0][7:0]), .a12(a[1][7:0]), .a21(a[2][7:0]), .a22(a[3][7:0]),
        .b11(b[0][7:0]), .b12(b[1][7:0]), .b21(b[2][7:0]), .b22(b[3][7:0]),
        .out_valid(ov[2]), .out_ready(out_ready),
        .c11(c8u[0]), .c12(c8u[1]), .c21(c8u[2]), .c22(c8u[3]),
        .busy(bsy[2])
    );

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            got[0][i] = c32[i];
            got[1][i] = {24'b0, c8s[i]};
            got[2][i] = {24'b0, c8u[i]};
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic int dwidth(input int d);
        return (d == 0) ? 32 : 8;
    endfunction

    function automatic bit dsigned(input int d);
        return (d != 2);
    endfunction

    function automatic logic signed [127:0] ext(input logic [31:0] v, input int w, input bit s);
        logic signed [127:0] r;
        r = '0;
        for (int i = 0; i < 128; i++) begin
            if (i < w) r[i] = v[i];
            else       r[i] = s & v[w-1];
        end
        return r;
    endfunction

    function automatic logic [31:0] reduce(input logic signed [127:0] x, input int w, input bit s);
        logic [31:0] r;
`ifdef STRASSEN_SAT_EN
        logic signed [127:0] mx, mn;
        if (s) begin
            mx = (128'sd1 <<< (w - 1)) - 128'sd1;
            mn = -(128'sd1 <<< (w - 1));
        end else begin
            mx = (128'sd1 <<< w) - 128'sd1;
            mn = '0;
        end
        if (x > mx)      x = mx;
        else if (x < mn) x = mn;
`endif
        r = '0;
        for (int i = 0; i < w; i++) r[i] = x[i];
        return r;
    endfunction

    task automatic model(input mat_t x, input mat_t y, input int d, output mat_t c);
        logic signed [127:0] p [4];
        logic signed [127:0] q [4];
        logic signed [127:0] e [4];
        for (int i = 0; i < 4; i++) begin
            p[i] = ext(x[i], dwidth(d), dsigned(d));
            q[i] = ext(y[i], dwidth(d), dsigned(d));
        end
        e[0] = p[0] * q[0] + p[1] * q[2];
        e[1] = p[0] * q[1] + p[1] * q[3];
        e[2] = p[2] * q[0] + p[3] * q[2];
        e[3] = p[2] * q[1] + p[3] * q[3];
        for (int i = 0; i < 4; i++) c[i] = reduce(e[i], dwidth(d), dsigned(d));
    endtask

    task automatic compute_expected(input mat_t x, input mat_t y);
        mat_t t;
        for (int d = 0; d < 3; d++) begin
            model(x, y, d, t);
            for (int i = 0; i < 4; i++) exp_c[d][i] = t[i];
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic start_job(input mat_t x, input mat_t y);
        int n;
        n = 0;
        while (irdy[0] !== 1'b1 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 40) begin
            asserts++;
            fails++;
            $display("[TB] FAIL start_job: in_ready never rose, got %b want 1", irdy[0]);
        end
        a = x;
        b = y;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (ov[0] !== 1'b1 && lat < 30);
    endtask

    function automatic mat_t rand_mat();
        mat_t m;
        for (int i = 0; i < 4; i++) m[i] = $urandom;
        return m;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = rand_mat();
        b = rand_mat();
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            asserts++;
            if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || bsy[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset flags dut%0d: got rdy=%b val=%b busy=%b want 1 0 0", d, irdy[d], ov[d], bsy[d]);
            end
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== 32'd0) begin
                    fails++;
                    $display("[TB] FAIL reset c dut%0d[%0d]: got %0h want 0", d, i, got[d][i]);
                end
            end
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        mat_t x, y;
        x = '{32'd1, 32'd2, 32'd3, 32'd4};
        y = '{32'd5, 32'd6, 32'd7, 32'd8};
        out_ready = 1'b1;
        compute_expected(x, y);
        start_job(x, y);
        asserts++;
        if (bsy[0] !== 1'b1 || irdy[0] !== 1'b0) begin
            fails++;
            $display("[TB] FAIL basic busy: got busy=%b rdy=%b want 1 0", bsy[0], irdy[0]);
        end
        wait_valid(lat);
        asserts++;
        if (lat !== 8) begin
            fails++;
            $display("[TB] FAIL basic latency: got %0d want 8", lat);
        end
        asserts++;
        if (c32[0] !== 32'd19 || c32[1] !== 32'd22 || c32[2] !== 32'd43 || c32[3] !== 32'd50) begin
            fails++;
            $display("[TB] FAIL basic C32: got %0d %0d %0d %0d want 19 22 43 50", c32[0], c32[1], c32[2], c32[3]);
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== exp_c[d][i]) begin
                    fails++;
                    $display("[TB] FAIL basic dut%0d c[%0d]: got %0h want %0h", d, i, got[d][i], exp_c[d][i]);
                end
            end
        end
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            asserts++;
            if (ov[d] !== 1'b0 || irdy[d] !== 1'b1) begin
                fails++;
                $display("[TB] FAIL basic release dut%0d: got val=%b rdy=%b want 0 1", d, ov[d], irdy[d]);
            end
        end
    endtask

    task automatic test_signed();
        int lat;
        mat_t x, y;
        x = '{32'hFFFF_FFFF, 32'd2, 32'd3, 32'hFFFF_FFFC};
        y = '{32'd1, 32'd0, 32'd0, 32'd1};
        out_ready = 1'b1;
        compute_expected(x, y);
        start_job(x, y);
        wait_valid(lat);
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== exp_c[d][i]) begin
                    fails++;
                    $display("[TB] FAIL signed dut%0d c[%0d]: got %0h want %0h", d, i, got[d][i], exp_c[d][i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_overflow();
        int lat;
        mat_t x;
        logic [31:0] want8s, want8u;
        x = '{32'd127, 32'd127, 32'd127, 32'd127};
`ifdef STRASSEN_SAT_EN
        want8s = 32'd127;
        want8u = 32'd255;
`else
        want8s = 32'd2;
        want8u = 32'd2;
`endif
        out_ready = 1'b1;
        compute_expected(x, x);
        start_job(x, x);
        wait_valid(lat);
        for (int i = 0; i < 4; i++) begin
            asserts++;
            if (got[0][i] !== 32'd32258 || got[1][i] !== want8s || got[2][i] !== want8u) begin
                fails++;
                $display("[TB] FAIL overflow c[%0d]: got %0d %0d %0d want %0d %0d %0d",
                         i, got[0][i], got[1][i], got[2][i], 32258, want8s, want8u);
            end
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== exp_c[d][i]) begin
                    fails++;
                    $display("[TB] FAIL overflow model dut%0d c[%0d]: got %0h want %0h", d, i, got[d][i], exp_c[d][i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat;
        mat_t x, y;
        x = rand_mat();
        y = rand_mat();
        out_ready = 1'b0;
        compute_expected(x, y);
        start_job(x, y);
        wait_valid(lat);
        asserts++;
        if (lat !== 8) begin
            fails++;
            $display("[TB] FAIL backpressure latency: got %0d want 8", lat);
        end
        for (int k = 0; k < 5; k++) begin
            a = rand_mat();
            b = rand_mat();
            in_valid = 1'b1;
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) begin
                asserts++;
                if (ov[d] !== 1'b1 || irdy[d] !== 1'b0 || bsy[d] !== 1'b1) begin
                    fails++;
                    $display("[TB] FAIL backpressure hold dut%0d cyc%0d: got val=%b rdy=%b busy=%b want 1 0 1",
                             d, k, ov[d], irdy[d], bsy[d]);
                end
                for (int i = 0; i < 4; i++) begin
                    asserts++;
                    if (got[d][i] !== exp_c[d][i]) begin
                        fails++;
                        $display("[TB] FAIL backpressure c dut%0d[%0d] cyc%0d: got %0h want %0h",
                                 d, i, k, got[d][i], exp_c[d][i]);
                    end
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            asserts++;
            if (ov[d] !== 1'b0 || irdy[d] !== 1'b1 || bsy[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL backpressure release dut%0d: got val=%b rdy=%b busy=%b want 0 1 0",
                         d, ov[d], irdy[d], bsy[d]);
            end
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        bit seen;
        mat_t x, y;
        out_ready = 1'b1;
        start_job(rand_mat(), rand_mat());
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int d = 0; d < 3; d++) begin
            asserts++;
            if (irdy[d] !== 1'b1 || ov[d] !== 1'b0 || bsy[d] !== 1'b0) begin
                fails++;
                $display("[TB] FAIL midreset flags dut%0d: got rdy=%b val=%b busy=%b want 1 0 0", d, irdy[d], ov[d], bsy[d]);
            end
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== 32'd0) begin
                    fails++;
                    $display("[TB] FAIL midreset c dut%0d[%0d]: got %0h want 0", d, i, got[d][i]);
                end
            end
        end
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++) if (ov[d] !== 1'b0) seen = 1'b1;
        end
        asserts++;
        if (seen) begin
            fails++;
            $display("[TB] FAIL midreset dropped job: got out_valid=1 want 0");
        end
        x = rand_mat();
        y = rand_mat();
        compute_expected(x, y);
        start_job(x, y);
        wait_valid(lat);
        asserts++;
        if (lat !== 8) begin
            fails++;
            $display("[TB] FAIL midreset latency: got %0d want 8", lat);
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 4; i++) begin
                asserts++;
                if (got[d][i] !== exp_c[d][i]) begin
                    fails++;
                    $display("[TB] FAIL midreset after dut%0d c[%0d]: got %0h want %0h", d, i, got[d][i], exp_c[d][i]);
                end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        mat_t ja [4];
        mat_t jb [4];
        logic [31:0] bexp [4][3][4];
        logic [31:0] rval [3][4][4];
        int rtime [3][4];
        int rcnt [3];
        for (int k = 0; k < 4; k++) begin
            ja[k] = rand_mat();
            jb[k] = rand_mat();
            compute_expected(ja[k], jb[k]);
            for (int d = 0; d < 3; d++)
                for (int i = 0; i < 4; i++) bexp[k][d][i] = exp_c[d][i];
        end
        for (int d = 0; d < 3; d++) rcnt[d] = 0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        a = ja[0];
        b = jb[0];
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int n = 1; n <= 45; n++) begin
            @(posedge clk); #1;
            if ((n % 10) == 1 && (n / 10) < 3) begin
                a = ja[n / 10 + 1];
                b = jb[n / 10 + 1];
            end
            if (n == 31) in_valid = 1'b0;
            for (int d = 0; d < 3; d++) begin
                if (ov[d] === 1'b1) begin
                    if (rcnt[d] < 4) begin
                        rtime[d][rcnt[d]] = n;
                        for (int i = 0; i < 4; i++) rval[d][rcnt[d]][i] = got[d][i];
                    end
                    rcnt[d]++;
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            asserts++;
            if (rcnt[d] !== 4) begin
                fails++;
                $display("[TB] FAIL b2b count dut%0d: got %0d want 4", d, rcnt[d]);
            end
            for (int k = 0; k < 4 && k < rcnt[d]; k++) begin
                asserts++;
                if (rtime[d][k] !== 10 * k + 8) begin
                    fails++;
                    $display("[TB] FAIL b2b timing dut%0d job%0d: got %0d want %0d", d, k, rtime[d][k], 10 * k + 8);
                end
                for (int i = 0; i < 4; i++) begin
                    asserts++;
                    if (rval[d][k][i] !== bexp[k][d][i]) begin
                        fails++;
                        $display("[TB] FAIL b2b dut%0d job%0d c[%0d]: got %0h want %0h",
                                 d, k, i, rval[d][k][i], bexp[k][d][i]);
                    end
                end
            end
        end
    endtask

    initial begin
        asserts = 0;
        fails = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a[i] = '0;
            b[i] = '0;
        end
        $display("[TB] starting strassen_2x2_seq bench");
        test_reset();
        test_basic();
        test_signed();
        test_overflow();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
